// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divide sequencer.
//   div_state_e     : sequencer states
//   DIV_OP_UNSIGNED : div_op bit selecting unsigned operation
//   DIV_OP_REM      : div_op bit selecting remainder (mod) instead of quotient
//   DIV_WIDTH       : default operand/result width
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  localparam int DIV_OP_UNSIGNED = 0;
  localparam int DIV_OP_REM      = 1;
  localparam int DIV_WIDTH       = 32;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
//   rem_i / quo_i : partial remainder and shifting quotient/dividend register
//   div_i         : divisor magnitude
//   rem_o / quo_o : values after shifting {rem, quo} left by one and a
//                   conditional subtract that sets the new quotient LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder needs one extra bit before the compare.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, div_i});
    // When ge holds the true difference fits in WIDTH bits, so modulo
    // arithmetic on the low bits is exact.
    diff   = rem_sh[WIDTH-1:0] - div_i;
    rem_o  = ge ? diff : rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative divide sequencer for div.w/div.wu/mod.w/mod.wu.
//   clk, resetn          : clock, async active-low reset
//   flush                : abort any operation (priority over ack/req)
//   div_req, div_op      : request and op (bit0 unsigned, bit1 remainder)
//   div_src1, div_src2   : dividend, divisor (sampled only when leaving IDLE)
//   div_ack              : consumer accepts result, honoured only in DONE
//   div_busy             : state is not IDLE
//   div_done, div_result : registered result-valid and held result
// Flow: IDLE -> PREP -> CALC (WIDTH steps on magnitudes) -> FIX (sign fix
// and select) -> DONE (hold until ack).
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             div_req,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_ack,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d;
  logic             s1_neg_q, s1_neg_d;
  logic             s2_neg_q, s2_neg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             is_signed;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (divisor_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    s1_neg_d  = s1_neg_q;
    s2_neg_d  = s2_neg_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    done_d    = done_q;

    is_signed = ~div_op[DIV_OP_UNSIGNED];
    // Signs were forced to 0 for unsigned ops, so no fix happens there.
    quo_fix   = (s1_neg_q ^ s2_neg_q) ? -quo_q : quo_q;
    rem_fix   = s1_neg_q ? -rem_q : rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_req) begin
          state_d   = S_PREP;
          rem_sel_d = div_op[DIV_OP_REM];
          s1_neg_d  = is_signed & div_src1[WIDTH-1];
          s2_neg_d  = is_signed & div_src2[WIDTH-1];
          // The quotient register starts out holding the dividend magnitude;
          // its bits shift into rem as quotient bits shift in from the LSB.
          quo_d     = (is_signed & div_src1[WIDTH-1]) ? -div_src1 : div_src1;
          divisor_d = (is_signed & div_src2[WIDTH-1]) ? -div_src2 : div_src2;
        end
      end
      S_PREP: begin
        state_d = S_CALC;
        rem_d   = '0;
        cnt_d   = '0;
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d  = S_DONE;
        result_d = rem_sel_q ? rem_fix : quo_fix;
        done_d   = 1'b1;
      end
      S_DONE: begin
        if (div_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase

    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      s1_neg_q  <= 1'b0;
      s2_neg_q  <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      s1_neg_q  <= s1_neg_d;
      s2_neg_q  <= s2_neg_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign div_busy   = (state_q != S_IDLE);
  assign div_done   = done_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench for div_seq_ctrl with a latency/arithmetic
// reference model compared every cycle plus literal expectations.
module tb_div_seq_ctrl;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          div_req;
  logic [1:0]    div_op;
  logic [W-1:0]  div_src1, div_src2;
  logic          div_ack;
  logic          div_busy, div_done;
  logic [W-1:0]  div_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .div_req    (div_req),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_ack    (div_ack),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic reference straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (op[0]) begin
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      return op[1] ? a % b : a / b;
    end
    if (b == 0) return op[1] ? a : ((sa < 0) ? 32'd1 : 32'hFFFF_FFFF);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    return op[1] ? sa % sb : sa / sb;
  endfunction

  // Model: 0 idle, 1 busy (counting down to done), 2 result held.
  int          m_ph;
  int          m_left;
  logic [31:0] m_pend, m_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph <= 0; m_left <= 0; m_pend <= '0; m_res <= '0;
    end else if (flush) begin
      m_ph <= 0;
    end else begin
      case (m_ph)
        0: if (div_req) begin
             m_ph   <= 1;
             m_left <= W + 2;
             m_pend <= ref_div(div_op, div_src1, div_src2);
           end
        1: if (m_left == 1) begin m_ph <= 2; m_res <= m_pend; end
           else m_left <= m_left - 1;
        default: if (div_ack) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if (div_busy !== (m_ph != 0) || div_done !== (m_ph == 2) || div_result !== m_res) begin
      n_fail++;
      $display("FAIL cycle %0d model: busy/done/result got %b/%b/%h expected %b/%b/%h",
               cyc, div_busy, div_done, div_result, m_ph != 0, m_ph == 2, m_res);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for div_done with a bound; returns cycles elapsed since c0.
  task automatic wait_done(input int c0, input string nm);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (div_done) got = 1;
      else tick();
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(cyc - c0), 32'(LAT));
  endtask

  // ack_wait < 0: ack tied high for the whole operation.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int ack_wait, input string nm);
    int c0;
    div_op = op; div_src1 = a; div_src2 = b; div_req = 1'b1;
    if (ack_wait < 0) div_ack = 1'b1;
    c0 = cyc;
    tick();
    div_req = 1'b0;
    wait_done(c0, nm);
    chk({nm, " result"}, div_result, exp);
    if (ack_wait >= 0) begin
      div_ack = 1'b0;
      repeat (ack_wait) tick();
      chk({nm, " held result"}, div_result, exp);
      div_ack = 1'b1;
    end
    tick();
    div_ack = 1'b0;
    chk({nm, " idle after ack"}, {30'd0, div_busy, div_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    resetn = 1'b0; flush = 1'b0; div_req = 1'b0; div_op = 2'b00;
    div_src1 = '0; div_src2 = '0; div_ack = 1'b0;
    tick(); tick();
    chk("reset outputs", {div_result[29:0], div_busy, div_done}, 32'd0);
    chk("reset result", div_result, 32'd0);
    resetn = 1'b1;
    tick();

    // Basic unsigned with ack tied high.
    do_op(2'b01, 32'd100, 32'd7, 32'd14, -1, "divwu 100/7");
    do_op(2'b11, 32'd100, 32'd7, 32'd2, -1, "modwu 100/7");
    // Signed and overflow.
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "modw -7/2");
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "divw -7/2");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "divw ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "modw ovf");
    // Divide by zero.
    do_op(2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, "divwu 7/0");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, "modw -7/0");
    // Mixed signs and wide unsigned.
    do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, "divw 100/-7");
    do_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 0, "modw 100/-7");
    do_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0, "divw -100/-7");
    do_op(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, "modw -100/-7");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, "divwu max/1");
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 0, "modwu max/16");

    // Ack held off 10 cycles, then back-to-back request in the IDLE cycle.
    do_op(2'b01, 32'd1000, 32'd10, 32'd100, 10, "ack delay");
    do_op(2'b01, 32'd81, 32'd9, 32'd9, 0, "after ack delay");

    // Flush mid-operation with request held.
    div_op = 2'b01; div_src1 = 32'd50; div_src2 = 32'd5; div_req = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush idle", {30'd0, div_busy, div_done}, 32'd0);
    do_op(2'b00, 32'd9, 32'd3, 32'd3, 0, "after flush 9/3");

    // Flush together with ack in DONE.
    div_op = 2'b01; div_src1 = 32'd20; div_src2 = 32'd4; div_req = 1'b1;
    c0 = cyc;
    tick();
    div_req = 1'b0;
    wait_done(c0, "flush+ack");
    chk("flush+ack result", div_result, 32'd5);
    flush = 1'b1; div_ack = 1'b1;
    tick();
    flush = 1'b0; div_ack = 1'b0;
    chk("flush+ack idle", {30'd0, div_busy, div_done}, 32'd0);

    // Reset mid-CALC clears outputs immediately.
    div_op = 2'b01; div_src1 = 32'd77; div_src2 = 32'd7; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    repeat (19) tick();
    chk("pre-reset busy", {31'd0, div_busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async reset flags", {30'd0, div_busy, div_done}, 32'd0);
    chk("async reset result", div_result, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    do_op(2'b11, 32'd77, 32'd10, 32'd7, 0, "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
